// File: rtl/freq_counter_pkg.sv
// Shared definitions for the frequency-counter display path.
//   BCD_W   : width of one packed BCD digit (4 bits)
//   state_t : converter FSM encoding (IDLE / SHIFT / DONE)
//   pow10   : elaboration-time helper, 10**n as a 64-bit value
package freq_counter_pkg;

    localparam int BCD_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
// Result is at most 12, so a plain 4-bit add never overflows.
//   digit     : 4-bit BCD digit before correction
//   digit_adj : corrected digit
module bcd_add3
    import freq_counter_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [BCD_W-1:0] digit_adj
);

    assign digit_adj = (digit >= BCD_W'(5)) ? digit + BCD_W'(3) : digit;

endmodule

// File: rtl/freq_bcd_converter.sv
// Converts each finished gate-window count (binary) into packed BCD digits
// plus a leading-zero blank mask for the 7-segment driver. Sequential
// shift-add-3, one bit per clock; the last result is held between conversions.
//   clk        : system clock, posedge
//   rst_n      : asynchronous active-low reset
//   cnt_in     : binary count, sampled when cnt_valid=1 and idle
//   cnt_valid  : single-cycle strobe for cnt_in
//   bcd_out    : packed BCD, digit 0 (units) in [3:0]
//   blank      : bit i=1 when digit i is a leading zero (bit 0 always 0)
//   bcd_valid  : one-cycle pulse when bcd_out/blank update
//   busy       : conversion in progress
//   overrun    : sticky, a strobe arrived while busy
module freq_bcd_converter
    import freq_counter_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CNT_W-1:0]          cnt_in,
    input  logic                      cnt_valid,
    output logic [BCD_W*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]         blank,
    output logic                      bcd_valid,
    output logic                      busy,
    output logic                      overrun
);

    localparam int BCD_TOT = BCD_W * DIGITS;
    localparam int BC_W    = $clog2(CNT_W + 1);
    localparam logic [63:0] MAX_CNT = (64'd1 << CNT_W) - 64'd1;

    // The digit count must cover the largest possible count, otherwise the
    // top digit would silently wrap.
    generate
        if (pow10(DIGITS) <= MAX_CNT) begin : g_digits_too_few
            $error("freq_bcd_converter: DIGITS too small for CNT_W");
        end
    endgenerate

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     bin_sr_reg, bin_sr_next;
    logic [BCD_TOT-1:0]   bcd_sr_reg, bcd_sr_next;
    logic [BC_W-1:0]      bit_cnt_reg, bit_cnt_next;
    logic [BCD_TOT-1:0]   bcd_out_reg, bcd_out_next;
    logic [DIGITS-1:0]    blank_reg, blank_next;
    logic                 bcd_valid_reg, bcd_valid_next;
    logic                 busy_reg, busy_next;
    logic                 overrun_reg, overrun_next;

    logic [BCD_TOT-1:0]   bcd_adj;
    logic [DIGITS-1:0]    digit_zero;
    logic [DIGITS-1:0]    zero_run;
    logic [DIGITS-1:0]    blank_mask;

    // Per-digit add-3 correction ahead of each shift.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .digit     (bcd_sr_reg[gi*BCD_W +: BCD_W]),
                .digit_adj (bcd_adj[gi*BCD_W +: BCD_W])
            );
        end
    endgenerate

    // Leading-zero run from the top digit downwards.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_zero
            assign digit_zero[gi] = (bcd_sr_reg[gi*BCD_W +: BCD_W] == '0);
            if (gi == DIGITS - 1) begin : g_top
                assign zero_run[gi] = digit_zero[gi];
            end else begin : g_lower
                assign zero_run[gi] = digit_zero[gi] & zero_run[gi+1];
            end
        end
    endgenerate

    // Units digit is never blanked so a zero count still shows "0".
    assign blank_mask = zero_run & ~DIGITS'(1);

    always_comb begin
        state_next     = state_reg;
        bin_sr_next    = bin_sr_reg;
        bcd_sr_next    = bcd_sr_reg;
        bit_cnt_next   = bit_cnt_reg;
        bcd_out_next   = bcd_out_reg;
        blank_next     = blank_reg;
        bcd_valid_next = 1'b0;
        busy_next      = busy_reg;
        overrun_next   = overrun_reg;

        case (state_reg)
            IDLE: begin
                if (cnt_valid) begin
                    bin_sr_next  = cnt_in;
                    bcd_sr_next  = '0;
                    bit_cnt_next = '0;
                    busy_next    = 1'b1;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                bcd_sr_next  = {bcd_adj[BCD_TOT-2:0], bin_sr_reg[CNT_W-1]};
                bin_sr_next  = {bin_sr_reg[CNT_W-2:0], 1'b0};
                bit_cnt_next = bit_cnt_reg + BC_W'(1);
                if (bit_cnt_reg == BC_W'(CNT_W - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bcd_out_next   = bcd_sr_reg;
                blank_next     = blank_mask;
                bcd_valid_next = 1'b1;
                busy_next      = 1'b0;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase

        // A strobe while busy is dropped; only the sticky flag records it.
        if (cnt_valid && (state_reg != IDLE)) begin
            overrun_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            bin_sr_reg    <= '0;
            bcd_sr_reg    <= '0;
            bit_cnt_reg   <= '0;
            bcd_out_reg   <= '0;
            blank_reg     <= '0;
            bcd_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bin_sr_reg    <= bin_sr_next;
            bcd_sr_reg    <= bcd_sr_next;
            bit_cnt_reg   <= bit_cnt_next;
            bcd_out_reg   <= bcd_out_next;
            blank_reg     <= blank_next;
            bcd_valid_reg <= bcd_valid_next;
            busy_reg      <= busy_next;
            overrun_reg   <= overrun_next;
        end
    end

    assign bcd_out   = bcd_out_reg;
    assign blank     = blank_reg;
    assign bcd_valid = bcd_valid_reg;
    assign busy      = busy_reg;
    assign overrun   = overrun_reg;

endmodule
